boson_capture: RTL
==================

BOSON_CAPTURE -- requirements
Module: boson_capture

Interface
REQ-001 Parameter LINE_WIDTH, default 320; expected valid pixels per line.
REQ-002 Parameter FRAME_LINES, default 256; expected active lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 16, power of two; output pixel FIFO entries.
REQ-004 clk  input  1  system clock; frequency SHALL be at least 4x CMOS_CLK.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 CMOS_CLK  input  1  camera pixel clock, asynchronous to clk.
REQ-007 CMOS_VSYNC  input  1  low during vertical blanking, high during frame.
REQ-008 CMOS_HSYNC  input  1  low during horizontal sync.
REQ-009 CMOS_VALID  input  1  high while CMOS_DQ carries a pixel.
REQ-010 CMOS_DQ  input  16  pixel data; changes on CMOS_CLK falling edge.
REQ-011 m_data  output  16  pixel out.
REQ-012 m_sof  output  1  first pixel of a frame.
REQ-013 m_eol  output  1  last pixel of a line.
REQ-014 m_valid  output  1  output beat available.
REQ-015 m_ready  input  1  consumer accepts beat when m_valid and m_ready both high.
REQ-016 overflow  output  1  sticky; a pixel was dropped because the FIFO was full.
REQ-017 geom_err  output  1  sticky; line length or line count mismatch.
REQ-018 frame_count  output  16  completed frames (see REQ-037).
REQ-019 last_line_len  output  16  valid pixels in most recent line (see REQ-037).

Function
REQ-020 All CMOS_* inputs SHALL pass through a two-flop synchronizer into clk before use.
REQ-021 A CMOS_CLK rise SHALL be detected when the synchronized CMOS_CLK is 1 and its previous value is 0; one clk-wide sample strobe results.
REQ-022 On each sample strobe, synchronized VSYNC, HSYNC, VALID and DQ SHALL be captured together.
REQ-023 State machine: WAIT_BLANK, WAIT_FRAME, ACTIVE.
REQ-024 WAIT_BLANK -> WAIT_FRAME when a sample has VSYNC=0; pixels are discarded in WAIT_BLANK and WAIT_FRAME.
REQ-025 WAIT_FRAME -> ACTIVE when a sample has VSYNC=1; line counter and pixel counter are cleared; sof_pending is set.
REQ-026 ACTIVE -> WAIT_FRAME when a sample has VSYNC=0; frame_count increments if the line count equals FRAME_LINES, else geom_err is set.
REQ-027 In ACTIVE, each sample with VALID=1 SHALL place the pixel into a one-entry hold register; any previously held pixel is pushed to the FIFO with eol=0.
REQ-028 A VALID 1->0 transition between samples SHALL push the held pixel with eol=1, increment the line count, load last_line_len, and set geom_err if the pixel count is not LINE_WIDTH.
REQ-029 The first pixel pushed after entering ACTIVE SHALL carry sof=1; sof_pending then clears.
REQ-030 Pixel counter is 16 bits and SHALL saturate at 16'hFFFF.
REQ-031 If VSYNC falls while a pixel is held, that pixel SHALL be pushed with eol=1 before frame completion is evaluated, in the same sample.
REQ-032 FIFO full on push: the beat is dropped, overflow is set, and the state machine continues.
REQ-033 Simultaneous FIFO push and pop while full SHALL accept the push.
REQ-034 m_valid SHALL be high exactly when the FIFO is non-empty; m_data, m_sof and m_eol SHALL be stable while m_valid=1 and m_ready=0.
REQ-035 Latency from the CMOS_CLK rising edge to the FIFO push is at most 5 clk plus one pixel period, due to the hold register.

Reset
REQ-036 reset SHALL return the state machine to WAIT_BLANK, empty the FIFO, clear the hold register and all counters, and clear overflow and geom_err. After reset, m_valid=0, m_data=0, m_sof=0, m_eol=0. Reset asserted mid-line discards the partial line; capture resumes only after the next VSYNC low then high.

Configuration
REQ-037 Macro BOSON_CAPTURE_STATS_EN: when defined, frame_count and last_line_len behave per REQ-026 and REQ-028, with frame_count wrapping at 16 bits. When undefined, both are tied to 0 and their counters are not synthesized; geom_err checking remains.

Verification
REQ-038 Standard 263-line frame with 7 blanking lines, VALID samples 693-1011, released from reset mid-frame -> no output until the next VSYNC rise; then 256 lines of 319 beats each, the first beat with sof=1, each line's last beat with eol=1, geom_err=1 (319 != 320).
REQ-039 Same frame with LINE_WIDTH=319 and m_ready=1 throughout -> data values 1..81664 in order, geom_err=0, overflow=0, and frame_count=1 after VSYNC falls (STATS_EN defined).
REQ-040 m_ready=0 for a full line -> FIFO fills at 16 beats, overflow=1, beats 17-319 are dropped, and the first 16 beats are delivered intact once m_ready=1.
REQ-041 VSYNC falls while VALID=1 -> the held pixel is output with eol=1, and geom_err=1 from the short line and short frame.
REQ-042 reset pulsed for 1 clk at pixel 100 of a line -> all outputs are 0 the next cycle, and the next beat is sof=1 at the start of the following frame.
REQ-043 STATS_EN undefined -> frame_count=0 and last_line_len=0 throughout REQ-039's stimulus, while all other responses are unchanged.

Source files
------------

// File: rtl/boson_capture.sv
// ---------------------------------------------------------------------------
// boson_capture
//
// Captures the parallel CMOS video port of a Boson thermal core into the
// system clock domain. The camera pins are synchronized into clk and sampled
// once per camera pixel clock rising edge. A small state machine frames the
// video, and the pixels are delivered as a valid/ready stream through a
// pixel FIFO that tags each beat with start-of-frame and end-of-line.
//
// A one-entry hold register delays every pixel by one sample. This lets the
// end-of-line flag be attached to the last pixel of a line when VALID falls
// (or VSYNC falls) on the following sample.
//
// Parameters
//   LINE_WIDTH   expected valid pixels per line
//   FRAME_LINES  expected active lines per frame
//   FIFO_DEPTH   output FIFO entries (power of two, >= 2)
//
// Ports
//   clk            system clock (at least 4x CMOS_CLK)
//   reset          synchronous, active-high reset
//   CMOS_CLK       camera pixel clock, asynchronous to clk
//   CMOS_VSYNC     low during vertical blanking, high during a frame
//   CMOS_HSYNC     low during horizontal sync
//   CMOS_VALID     high while CMOS_DQ carries a pixel
//   CMOS_DQ[15:0]  pixel data, changes on the CMOS_CLK falling edge
//   m_data[15:0]   output pixel
//   m_sof          output beat is the first pixel of a frame
//   m_eol          output beat is the last pixel of a line
//   m_valid        output beat available (FIFO non-empty)
//   m_ready        consumer accepts the beat when m_valid is also high
//   overflow       sticky: a pixel was dropped because the FIFO was full
//   geom_err       sticky: a line length or line count mismatch was seen
//   frame_count    completed frames (statistics build only, else 0)
//   last_line_len  pixels in the most recent line (statistics build only)
//
// Build option
//   BOSON_CAPTURE_STATS_EN  when defined, frame_count and last_line_len are
//                           maintained; when undefined both read as 0 and
//                           their counters are not built.
// ---------------------------------------------------------------------------
module boson_capture #(
  parameter int LINE_WIDTH  = 320,
  parameter int FRAME_LINES = 256,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CMOS_CLK,
  input  logic        CMOS_VSYNC,
  input  logic        CMOS_HSYNC,
  input  logic        CMOS_VALID,
  input  logic [15:0] CMOS_DQ,
  output logic [15:0] m_data,
  output logic        m_sof,
  output logic        m_eol,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        overflow,
  output logic        geom_err,
  output logic [15:0] frame_count,
  output logic [15:0] last_line_len
);

  localparam int          AW            = $clog2(FIFO_DEPTH);
  localparam logic [15:0] LINE_WIDTH_W  = 16'(LINE_WIDTH);
  localparam logic [15:0] FRAME_LINES_W = 16'(FRAME_LINES);

  localparam logic [1:0] ST_WAIT_BLANK = 2'd0;
  localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
  localparam logic [1:0] ST_ACTIVE     = 2'd2;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // -------------------------------------------------------------------------
  // Input synchronizer and pixel clock edge detect
  // -------------------------------------------------------------------------
  // All camera signals share one two-flop chain, so the synchronized data
  // lines up with the synchronized pixel clock. DQ changes on the falling
  // edge, so it has been stable for half a pixel period when the rising
  // edge is seen here.
  logic [19:0] cmos_in;
  logic [19:0] sync1_reg;
  logic [19:0] sync2_reg;
  logic        cmos_clk_prev_reg;

  assign cmos_in = {CMOS_CLK, CMOS_VSYNC, CMOS_HSYNC, CMOS_VALID, CMOS_DQ};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg         <= '0;
      sync2_reg         <= '0;
      cmos_clk_prev_reg <= 1'b0;
    end else begin
      sync1_reg         <= cmos_in;
      sync2_reg         <= sync1_reg;
      cmos_clk_prev_reg <= sync2_reg[19];
    end
  end

  logic        s_clk;
  logic        s_vsync;
  logic        s_hsync;
  logic        s_valid;
  logic [15:0] s_dq;
  logic        strobe;

  assign s_clk   = sync2_reg[19];
  assign s_vsync = sync2_reg[18];
  assign s_hsync = sync2_reg[17];
  assign s_valid = sync2_reg[16];
  assign s_dq    = sync2_reg[15:0];

  // One clk-wide strobe per camera pixel clock rising edge.
  assign strobe = s_clk & ~cmos_clk_prev_reg;

  // HSYNC travels through the synchronizer with the other pins, but line
  // framing is taken from VALID alone.
  logic unused_hsync;
  assign unused_hsync = s_hsync;

  // -------------------------------------------------------------------------
  // Framing state machine
  // -------------------------------------------------------------------------
  logic [1:0]  state_reg,      state_next;
  logic        hold_valid_reg, hold_valid_next;
  logic [15:0] hold_data_reg,  hold_data_next;
  logic [15:0] pix_count_reg,  pix_count_next;
  logic [15:0] line_count_reg, line_count_next;
  logic        sof_pending_reg, sof_pending_next;
  logic        geom_err_reg,   geom_err_next;
  logic        push;
  logic        push_eol;
  logic        push_sof;
  logic        line_end;
  logic        frame_done;

  always_comb begin
    state_next       = state_reg;
    hold_valid_next  = hold_valid_reg;
    hold_data_next   = hold_data_reg;
    pix_count_next   = pix_count_reg;
    line_count_next  = line_count_reg;
    sof_pending_next = sof_pending_reg;
    geom_err_next    = geom_err_reg;
    push             = 1'b0;
    push_eol         = 1'b0;
    line_end         = 1'b0;
    frame_done       = 1'b0;

    if (strobe) begin
      case (state_reg)
        ST_WAIT_BLANK: begin
          if (!s_vsync) begin
            state_next = ST_WAIT_FRAME;
          end
        end

        ST_WAIT_FRAME: begin
          if (s_vsync) begin
            state_next       = ST_ACTIVE;
            line_count_next  = '0;
            pix_count_next   = '0;
            hold_valid_next  = 1'b0;
            sof_pending_next = 1'b1;
          end
        end

        ST_ACTIVE: begin
          // The hold register is occupied exactly when the previous sample
          // had VALID=1, so a held pixel meeting VALID=0 or VSYNC=0 closes
          // the line. This runs before frame completion is judged, so a line
          // cut short by VSYNC is still counted.
          if (hold_valid_reg && (!s_vsync || !s_valid)) begin
            push            = 1'b1;
            push_eol        = 1'b1;
            line_end        = 1'b1;
            hold_valid_next = 1'b0;
            pix_count_next  = '0;
            line_count_next = sat_inc(line_count_reg);
            if (pix_count_reg != LINE_WIDTH_W) begin
              geom_err_next = 1'b1;
            end
          end

          if (!s_vsync) begin
            state_next = ST_WAIT_FRAME;
            frame_done = 1'b1;
            if (line_count_next != FRAME_LINES_W) begin
              geom_err_next = 1'b1;
            end
          end else if (s_valid) begin
            // A new pixel displaces the held one, which is not a line end.
            if (hold_valid_reg) begin
              push     = 1'b1;
              push_eol = 1'b0;
            end
            hold_valid_next = 1'b1;
            hold_data_next  = s_dq;
            pix_count_next  = sat_inc(pix_count_reg);
          end
        end

        default: begin
          state_next = ST_WAIT_BLANK;
        end
      endcase
    end

    // The first beat offered to the FIFO in a frame carries sof.
    if (push) begin
      sof_pending_next = 1'b0;
    end
  end

  assign push_sof = sof_pending_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_WAIT_BLANK;
      hold_valid_reg  <= 1'b0;
      hold_data_reg   <= '0;
      pix_count_reg   <= '0;
      line_count_reg  <= '0;
      sof_pending_reg <= 1'b0;
      geom_err_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      hold_valid_reg  <= hold_valid_next;
      hold_data_reg   <= hold_data_next;
      pix_count_reg   <= pix_count_next;
      line_count_reg  <= line_count_next;
      sof_pending_reg <= sof_pending_next;
      geom_err_reg    <= geom_err_next;
    end
  end

  assign geom_err = geom_err_reg;

  // -------------------------------------------------------------------------
  // Output pixel FIFO
  // -------------------------------------------------------------------------
  // Pointers carry one extra wrap bit to tell full from empty. The head
  // entry is read combinationally so that m_valid tracks non-empty with no
  // extra storage stage; total capacity is exactly FIFO_DEPTH beats.
  logic [17:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;
  logic          overflow_reg;
  logic [17:0]   head_word;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop        = !fifo_empty && m_ready;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // still accepted then.
  assign push_ok    = push && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= {push_sof, push_eol, hold_data_reg};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !push_ok) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign head_word = mem[rd_ptr_reg[AW-1:0]];
  assign m_valid   = !fifo_empty;
  // Gate the head so the outputs read zero whenever nothing is queued,
  // including straight after reset when the storage is undefined.
  assign m_data    = m_valid ? head_word[15:0] : 16'd0;
  assign m_eol     = m_valid & head_word[16];
  assign m_sof     = m_valid & head_word[17];
  assign overflow  = overflow_reg;

  // -------------------------------------------------------------------------
  // Optional statistics
  // -------------------------------------------------------------------------
`ifdef BOSON_CAPTURE_STATS_EN
  logic [15:0] frame_count_reg;
  logic [15:0] last_line_len_reg;
  logic        frame_ok;

  assign frame_ok = frame_done && (line_count_next == FRAME_LINES_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_reg   <= '0;
      last_line_len_reg <= '0;
    end else begin
      if (frame_ok) begin
        frame_count_reg <= frame_count_reg + 16'd1;
      end
      if (line_end) begin
        last_line_len_reg <= pix_count_reg;
      end
    end
  end

  assign frame_count   = frame_count_reg;
  assign last_line_len = last_line_len_reg;
`else
  logic unused_stats;
  assign unused_stats  = frame_done ^ line_end;
  assign frame_count   = 16'd0;
  assign last_line_len = 16'd0;
`endif

endmodule
